// File: rtl/nvdla_reset_seq.sv
// ============================================================================
//  Module   : nvdla_reset_seq
//  Brief    : NVDLA core reset sequencer. Synchronises extra reset sources
//             and a soft-reset request into nvdla_clk, enforces a minimum
//             clean hold, releases partition resets in staged index order
//             and keeps a sticky reset-cause register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nvdla_reset_seq #(
  parameter int NUM_SRC    = 2,
  parameter int SYNC_DEPTH = 3,
  parameter int NUM_OUT    = 4,
  parameter int MIN_ASSERT = 8,
  parameter int STAGE_DLY  = 16
) (
  input  logic               nvdla_clk,
  input  logic               dla_reset_rstn,
  input  logic               direct_reset_,
  input  logic               test_mode,
  input  logic [NUM_SRC-1:0] src_rstn,
  input  logic               sw_reset_req,
  input  logic               status_clr,
  output logic [NUM_OUT-1:0] out_rstn,
  output logic               reset_busy,
  output logic [NUM_SRC:0]   rst_cause
);

  // Counter must reach the larger of the hold and stage intervals.
  localparam int c_MAX_CNT = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam int c_K_W     = $clog2(NUM_OUT + 1);

  localparam logic [1:0] c_ST_RST  = 2'd0;
  localparam logic [1:0] c_ST_HOLD = 2'd1;
  localparam logic [1:0] c_ST_REL  = 2'd2;
  localparam logic [1:0] c_ST_RUN  = 2'd3;

  logic [NUM_SRC-1:0] w_sync_out;
  logic               w_combined;
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_K_W-1:0]   r_k;
  logic [NUM_OUT-1:0] r_out_rstn;
  logic [NUM_OUT-1:0] w_rel_mask;
  logic [NUM_SRC:0]   r_cause;
  logic               w_sw_accept;

  // One synchroniser per source: asserts asynchronously, releases through the chain.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    logic                  w_arst_n;
    logic [SYNC_DEPTH-1:0] r_chain;

    assign w_arst_n = src_rstn[i] & dla_reset_rstn;

    // Shift ones in after the source (and primary reset) deassert.
    always_ff @(posedge nvdla_clk or negedge w_arst_n) begin
      if (!w_arst_n) begin
        r_chain <= '0;
      end else begin
        r_chain <= {r_chain[SYNC_DEPTH-2:0], 1'b1};
      end
    end

    assign w_sync_out[i] = r_chain[SYNC_DEPTH-1];
  end

  assign w_combined  = &w_sync_out;
  assign w_sw_accept = (r_state == c_ST_RUN) && sw_reset_req;

  // One-hot mask selecting the partition released at the current stage.
  always_comb begin
    w_rel_mask = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      w_rel_mask[j] = (c_K_W'(j) == r_k);
    end
  end

  // Sequencer: hold for MIN_ASSERT clean cycles, then release one partition per STAGE_DLY.
  always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
    if (!dla_reset_rstn) begin
      r_state    <= c_ST_RST;
      r_cnt      <= '0;
      r_k        <= '0;
      r_out_rstn <= '0;
    end else begin
      case (r_state)
        c_ST_RST: begin
          r_out_rstn <= '0;
          r_k        <= '0;
          if (w_combined) begin
            r_state <= c_ST_HOLD;
            r_cnt   <= c_CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        c_ST_HOLD: begin
          if (!w_combined) begin
            r_state    <= c_ST_RST;
            r_cnt      <= '0;
            r_out_rstn <= '0;
          end else if (r_cnt == c_CNT_W'(MIN_ASSERT)) begin
            // A single-partition build has nothing left to stage.
            r_state       <= (NUM_OUT == 1) ? c_ST_RUN : c_ST_REL;
            r_out_rstn[0] <= 1'b1;
            r_cnt         <= c_CNT_W'(1);
            r_k           <= c_K_W'(1);
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_REL: begin
          if (!w_combined) begin
            r_state    <= c_ST_RST;
            r_cnt      <= '0;
            r_k        <= '0;
            r_out_rstn <= '0;
          end else if (r_cnt == c_CNT_W'(STAGE_DLY)) begin
            r_out_rstn <= r_out_rstn | w_rel_mask;
            r_k        <= r_k + c_K_W'(1);
            r_cnt      <= c_CNT_W'(1);
            if (r_k == c_K_W'(NUM_OUT - 1)) begin
              r_state <= c_ST_RUN;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          if (!w_combined || sw_reset_req) begin
            r_state    <= c_ST_RST;
            r_cnt      <= '0;
            r_k        <= '0;
            r_out_rstn <= '0;
          end
        end
      endcase
    end
  end

  // Sticky cause: sets take priority over a same-edge clear.
  always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
    if (!dla_reset_rstn) begin
      r_cause <= '0;
    end else begin
      r_cause <= (status_clr ? '0 : r_cause) | {w_sw_accept, ~w_sync_out};
    end
  end

  // Test mode overrides the partition resets after the flops.
  assign out_rstn   = test_mode ? {NUM_OUT{direct_reset_}} : r_out_rstn;
  assign reset_busy = ~&r_out_rstn;
  assign rst_cause  = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_nvdla_reset_seq.sv
// ============================================================================
//  Module   : tb_nvdla_reset_seq
//  Brief    : Directed self-checking bench for nvdla_reset_seq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nvdla_reset_seq;

  logic       nvdla_clk;
  logic       dla_reset_rstn;
  logic       direct_reset_;
  logic       test_mode;
  logic [1:0] src_rstn;
  logic       sw_reset_req;
  logic       status_clr;
  logic [3:0] out_rstn;
  logic       reset_busy;
  logic [2:0] rst_cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         off;
    logic [3:0] out;
    logic       busy;
  } step_t;

  typedef struct {
    logic       tm;
    logic       dr;
    logic [3:0] out;
    logic       busy;
  } tm_vec_t;

  step_t   steps [8];
  tm_vec_t tmv   [5];

  nvdla_reset_seq dut (
    .nvdla_clk      (nvdla_clk),
    .dla_reset_rstn (dla_reset_rstn),
    .direct_reset_  (direct_reset_),
    .test_mode      (test_mode),
    .src_rstn       (src_rstn),
    .sw_reset_req   (sw_reset_req),
    .status_clr     (status_clr),
    .out_rstn       (out_rstn),
    .reset_busy     (reset_busy),
    .rst_cause      (rst_cause)
  );

  initial nvdla_clk = 1'b0;
  always #5 nvdla_clk = ~nvdla_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count posedges from now; first release expected at edge f. Checks the
  // first n release steps. A nonzero pulse issues a one-cycle soft request
  // sampled at edge pulse+1.
  task automatic walk(input string name, input int f, input int n, input int pulse);
    int last;
    last = f + steps[n-1].off;
    for (int e = 1; e <= last; e++) begin
      @(posedge nvdla_clk);
      #1;
      for (int s = 0; s < n; s++) begin
        if (e - f == steps[s].off) begin
          chk($sformatf("%s_out_e%0d", name, e), 32'(out_rstn), 32'(steps[s].out));
          chk($sformatf("%s_busy_e%0d", name, e), 32'(reset_busy), 32'(steps[s].busy));
        end
      end
      sw_reset_req = (pulse != 0) && (e == pulse);
    end
    sw_reset_req = 1'b0;
  endtask

  initial begin
    steps[0] = '{-1, 4'b0000, 1'b1};
    steps[1] = '{ 0, 4'b0001, 1'b1};
    steps[2] = '{15, 4'b0001, 1'b1};
    steps[3] = '{16, 4'b0011, 1'b1};
    steps[4] = '{31, 4'b0011, 1'b1};
    steps[5] = '{32, 4'b0111, 1'b1};
    steps[6] = '{47, 4'b0111, 1'b1};
    steps[7] = '{48, 4'b1111, 1'b0};

    tmv[0] = '{1'b1, 1'b0, 4'b0000, 1'b0};
    tmv[1] = '{1'b1, 1'b1, 4'b1111, 1'b0};
    tmv[2] = '{1'b1, 1'b0, 4'b0000, 1'b0};
    tmv[3] = '{1'b0, 1'b0, 4'b1111, 1'b0};
    tmv[4] = '{1'b0, 1'b1, 4'b1111, 1'b0};

    dla_reset_rstn = 1'b0;
    direct_reset_  = 1'b0;
    test_mode      = 1'b0;
    src_rstn       = 2'b11;
    sw_reset_req   = 1'b0;
    status_clr     = 1'b0;

    // Reset state
    repeat (3) @(posedge nvdla_clk);
    #1;
    chk("rst_out", 32'(out_rstn), 32'h0);
    chk("rst_busy", 32'(reset_busy), 32'h1);
    chk("rst_cause", 32'(rst_cause), 32'h0);

    // 1. Power-on release: chains fill over 3 edges, then 8-cycle hold
    @(negedge nvdla_clk);
    dla_reset_rstn = 1'b1;
    walk("por", 12, 8, 0);
    chk("por_cause", 32'(rst_cause), 32'h3);

    // 2. Source 1 pulse, 12-edge latency to first release
    @(negedge nvdla_clk);
    status_clr = 1'b1;
    @(negedge nvdla_clk);
    status_clr = 1'b0;
    chk("clr_cause", 32'(rst_cause), 32'h0);
    src_rstn = 2'b01;
    repeat (2) @(posedge nvdla_clk);
    @(negedge nvdla_clk);
    src_rstn = 2'b11;
    walk("src1", 12, 8, 0);
    chk("src1_cause", 32'(rst_cause), 32'h2);

    // 3. Glitch during HOLD at cnt=5 restarts the full hold
    @(negedge nvdla_clk);
    src_rstn = 2'b01;
    @(negedge nvdla_clk);
    src_rstn = 2'b11;
    repeat (8) @(posedge nvdla_clk);
    @(negedge nvdla_clk);
    src_rstn = 2'b10;
    @(posedge nvdla_clk);
    #1;
    chk("glitch_out", 32'(out_rstn), 32'h0);
    chk("glitch_cause0", 32'(rst_cause[0]), 32'h1);
    @(negedge nvdla_clk);
    src_rstn = 2'b11;
    walk("glitch", 12, 8, 0);

    // 4. Abort after two partitions released
    @(negedge nvdla_clk);
    src_rstn = 2'b10;
    @(negedge nvdla_clk);
    src_rstn = 2'b11;
    walk("pre_abort", 12, 4, 0);
    @(negedge nvdla_clk);
    src_rstn = 2'b10;
    @(posedge nvdla_clk);
    #1;
    chk("abort_out", 32'(out_rstn), 32'h0);
    chk("abort_busy", 32'(reset_busy), 32'h1);
    @(negedge nvdla_clk);
    src_rstn = 2'b11;
    walk("abort", 12, 8, 0);

    // 5. Soft reset pulse; a second pulse during REL is ignored
    @(negedge nvdla_clk);
    status_clr = 1'b1;
    @(negedge nvdla_clk);
    status_clr   = 1'b0;
    sw_reset_req = 1'b1;
    @(posedge nvdla_clk);
    #1;
    sw_reset_req = 1'b0;
    chk("sw_out", 32'(out_rstn), 32'h0);
    chk("sw_busy", 32'(reset_busy), 32'h1);
    chk("sw_cause", 32'(rst_cause), 32'h4);
    walk("sw", 9, 8, 14);

    // 6. Clear with simultaneous set keeps only the new bit
    @(negedge nvdla_clk);
    status_clr = 1'b1;
    src_rstn   = 2'b01;
    @(posedge nvdla_clk);
    #1;
    chk("clrset_cause", 32'(rst_cause), 32'h2);
    @(negedge nvdla_clk);
    status_clr = 1'b0;
    src_rstn   = 2'b11;
    walk("clrset", 12, 8, 0);

    // Test-mode bypass, checked combinationally mid-cycle
    @(negedge nvdla_clk);
    for (int v = 0; v < 5; v++) begin
      test_mode     = tmv[v].tm;
      direct_reset_ = tmv[v].dr;
      #1;
      chk($sformatf("tm_out_%0d", v), 32'(out_rstn), 32'(tmv[v].out));
      chk($sformatf("tm_busy_%0d", v), 32'(reset_busy), 32'(tmv[v].busy));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
